hdr_target_engine: RTL

Parametrised I3C HDR-DDR target engine that sequences entry into HDR, command reception, and dispatch to one of NUM_HANDLERS transfer handlers (normal transfer, CCC, and any added later). It sits between the ENTHDR/exit/restart detectors, the RX deserialiser and the handler blocks, and drives the shared-bus mux select. It adds three things the previous engine lacked: an arbitrary handler count, EXIT/RESTART abort from every HDR state, and an optional watchdog.

---
 rtl/hdr_tgt_pkg.sv | 26 ++
 rtl/hdr_tgt_watchdog.sv | 29 ++
 rtl/hdr_target_engine.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/hdr_tgt_pkg.sv
// Shared types and constants for the I3C HDR-DDR target engine: FSM states,
// RX deserialiser modes, decision and bus-owner codes.
package hdr_tgt_pkg;

   typedef enum logic [1:0] {
      IDLE_SDR   = 2'd0,
      IDLE_HDR   = 2'd1,
      INITIALIZE = 2'd2,
      HANDLER    = 2'd3
   } state_t;

   localparam logic [3:0] INITIALIZING     = 4'b0000;
   localparam logic [3:0] PREAMBLE         = 4'b0001;
   localparam logic [3:0] CMD_WORD         = 4'b0010;
   localparam logic [3:0] DATA_WORD        = 4'b0011;
   localparam logic [3:0] CRC_WORD         = 4'b0100;
   localparam logic [3:0] PARITY           = 4'b0101;
   localparam logic [3:0] ABORT            = 4'b0110;
   localparam logic [3:0] RESTART          = 4'b0111;
   localparam logic [3:0] EXIT             = 4'b1000;
   localparam logic [3:0] SPECIAL_PREAMBLE = 4'b1001;

   localparam int unsigned NOT_ME = 0;
   localparam int unsigned ENGINE = 0;

endpackage

// File: rtl/hdr_tgt_watchdog.sv
// Cycle counter that flags expiry after LIMIT cycles of i_en since the last i_clr.
// Expire is combinational from the count; the count saturates at LIMIT-1.
module hdr_tgt_watchdog #(
   parameter int LIMIT = 256
) (
   input  logic i_sys_clk,
   input  logic i_sys_rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire
);

   localparam int CNT_W = (LIMIT > 2) ? $clog2(LIMIT) : 1;

   logic [CNT_W-1:0] cnt;

   assign o_expire = i_en && (cnt == CNT_W'(LIMIT - 1));

   always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
      if (i_sys_rst) begin
         cnt <= '0;
      end else if (i_clr) begin
         cnt <= '0;
      end else if (i_en && !o_expire) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/hdr_target_engine.sv
// HDR-DDR target engine: ENTHDR entry, command decode and dispatch to NUM_HANDLERS handlers.
// Moore outputs, 1-cycle latency; optional watchdog under HDR_TGT_ENGINE_WATCHDOG_EN.
module hdr_target_engine
   import hdr_tgt_pkg::*;
#(
   parameter int NUM_HANDLERS = 2,
   parameter int TIMEOUT_CYC  = 256,
   parameter int DEC_W        = $clog2(NUM_HANDLERS + 2),
   parameter int SEL_W        = $clog2(NUM_HANDLERS + 1)
) (
   input  logic                    i_sys_clk,
   input  logic                    i_sys_rst,
   input  logic                    i_enthdr_done,
   input  logic                    i_exitdet_exit,
   input  logic                    i_rstdet_restart,
   input  logic [DEC_W-1:0]        i_rx_decision,
   input  logic                    i_rx_decision_done,
   input  logic [NUM_HANDLERS-1:0] i_handler_done,
   output logic                    o_enthdr_en,
   output logic                    o_rx_en,
   output logic [3:0]              o_rx_mode,
   output logic [NUM_HANDLERS-1:0] o_handler_en,
   output logic [SEL_W-1:0]        o_muxes,
   output logic                    o_error,
   output logic                    o_timeout
);

   localparam int IDX_W = (NUM_HANDLERS > 1) ? $clog2(NUM_HANDLERS) : 1;

   state_t           state, state_nxt;
   logic [IDX_W-1:0] act_idx, act_idx_nxt;
   logic             err_set, tmo_set, err_q;
   logic             dec_err, hdl_done, wd_expire;

   assign dec_err  = i_rx_decision > DEC_W'(NUM_HANDLERS);
   assign hdl_done = i_handler_done[act_idx];

   always_comb begin
      state_nxt   = state;
      act_idx_nxt = act_idx;
      err_set     = 1'b0;
      tmo_set     = 1'b0;
      case (state)
         IDLE_SDR: begin
            if (i_enthdr_done) state_nxt = INITIALIZE;
         end
         IDLE_HDR: begin
            if (i_exitdet_exit)        state_nxt = IDLE_SDR;
            else if (i_rstdet_restart) state_nxt = INITIALIZE;
         end
         INITIALIZE: begin
            if (i_exitdet_exit) begin
               state_nxt = IDLE_SDR;
            end else if (i_rstdet_restart) begin
               state_nxt = INITIALIZE;
            end else if (i_rx_decision_done) begin
               if (i_rx_decision == DEC_W'(NOT_ME)) begin
                  state_nxt = IDLE_HDR;
               end else if (dec_err) begin
                  state_nxt = IDLE_HDR;
                  err_set   = 1'b1;
               end else begin
                  state_nxt   = HANDLER;
                  act_idx_nxt = IDX_W'(i_rx_decision - DEC_W'(1));
               end
            end else if (wd_expire) begin
               state_nxt = IDLE_HDR;
               tmo_set   = 1'b1;
            end
         end
         HANDLER: begin
            if (i_exitdet_exit) begin
               state_nxt = IDLE_SDR;
            end else if (i_rstdet_restart) begin
               state_nxt = INITIALIZE;
            end else if (hdl_done) begin
               state_nxt = IDLE_HDR;
            end else if (wd_expire) begin
               state_nxt = IDLE_HDR;
               tmo_set   = 1'b1;
            end
         end
         default: state_nxt = IDLE_SDR;
      endcase
   end

   always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
      if (i_sys_rst) begin
         state   <= IDLE_SDR;
         act_idx <= '0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_nxt;
         act_idx <= act_idx_nxt;
         err_q   <= err_set;
      end
   end

   assign o_error = err_q;

`ifdef HDR_TGT_ENGINE_WATCHDOG_EN
   logic wd_busy, wd_clr, tmo_q;

   // A restart re-entry keeps the same state but must still restart the count.
   assign wd_busy = (state == INITIALIZE) || (state == HANDLER);
   assign wd_clr  = ((state_nxt == INITIALIZE) || (state_nxt == HANDLER)) &&
                    ((state_nxt != state) || (wd_busy && !i_exitdet_exit && i_rstdet_restart));

   hdr_tgt_watchdog #(
      .LIMIT (TIMEOUT_CYC)
   ) u_watchdog (
      .i_sys_clk (i_sys_clk),
      .i_sys_rst (i_sys_rst),
      .i_clr     (wd_clr),
      .i_en      (wd_busy),
      .o_expire  (wd_expire)
   );

   always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
      if (i_sys_rst) tmo_q <= 1'b0;
      else           tmo_q <= tmo_set;
   end

   assign o_timeout = tmo_q;
`else
   assign wd_expire = 1'b0;
   // tmo_set can never rise without the watchdog, so this is constant 0.
   assign o_timeout = tmo_set;

   if (TIMEOUT_CYC < 2) begin : g_timeout_unused
   end
`endif

   always_comb begin
      o_enthdr_en  = 1'b0;
      o_rx_en      = 1'b0;
      o_rx_mode    = INITIALIZING;
      o_handler_en = '0;
      o_muxes      = SEL_W'(ENGINE);
      case (state)
         IDLE_SDR:   o_enthdr_en = 1'b1;
         INITIALIZE: o_rx_en     = 1'b1;
         HANDLER: begin
            o_handler_en[act_idx] = 1'b1;
            o_muxes               = SEL_W'(act_idx) + SEL_W'(1);
         end
         default: ;
      endcase
   end

endmodule
